// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage, ready/valid data port with byte enables and load extension.
// Optional memory-mapped output port enabled by defining LSU_OUTPORT_EN.
module load_store_unit #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] OUTPORT_ADDR = 32'h0000_FFFC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rdata,
`ifdef LSU_OUTPORT_EN
   output logic [31:0]       outport,
`endif
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              fault
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ISSUE = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] RESP  = 3'd3;
   localparam logic [2:0] ERR   = 3'd4;
`ifdef LSU_OUTPORT_EN
   localparam logic OUT_EN = 1'b1;
   logic [31:0] outport_q, outport_d;
   assign outport = outport_q;
`else
   localparam logic OUT_EN = 1'b0;
`endif
   logic [2:0]        state_q, state_d;
   logic              is_store_q, is_store_d, hit_q, hit_d, we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d, wb_rd_q, wb_rd_d;
   logic [3:0]        be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, wb_data_q, wb_data_d;
   logic              accept, illegal, misal;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;
   logic [31:0]       ld_data;
   assign req_ready     = state_q == IDLE;
   assign mem_req_valid = (state_q == ISSUE) & ~hit_q;
   assign wb_valid      = state_q == RESP;
   assign fault         = state_q == ERR;
   assign mem_we        = we_q;
   assign mem_be        = be_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign accept  = req_valid & req_ready;
   assign illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11) | (req_is_store & req_funct3[2]);
   assign misal   = ((req_funct3[1:0] == 2'b01) & req_addr[0]) | ((req_funct3[1:0] == 2'b10) & |req_addr[1:0]);
   assign ld_b    = 8'(mem_rdata >> {off_q, 3'b000});
   assign ld_h    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   assign ld_data = f3_q[1] ? mem_rdata :
                    f3_q[0] ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} : {{24{~f3_q[2] & ld_b[7]}}, ld_b};
   // next-state: capture request on accept, sequence the memory handshake and writeback
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      hit_d      = hit_q;
      we_d       = we_q;
      f3_d       = f3_q;
      off_d      = off_q;
      rd_d       = rd_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
`ifdef LSU_OUTPORT_EN
      outport_d  = outport_q;
`endif
      case (state_q)
         IDLE: if (accept) begin
            is_store_d = req_is_store;
            hit_d      = OUT_EN & req_is_store & (req_funct3 == 3'b010) & (req_addr == OUTPORT_ADDR);
            we_d       = req_is_store;
            f3_d       = req_funct3;
            off_d      = req_addr[1:0];
            rd_d       = req_rd;
            addr_d     = {req_addr[ADDR_W-1:2], 2'b00};
            be_d       = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                         req_funct3[1:0] == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
            wdata_d    = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                         req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
            state_d    = (illegal | misal) ? ERR : ISSUE;
         end
         ISSUE: if (hit_q) begin
`ifdef LSU_OUTPORT_EN
            outport_d = wdata_q;
`endif
            state_d   = IDLE;
         end else if (mem_req_ready) begin
            state_d = is_store_q ? IDLE : WAIT;
         end
         WAIT: if (mem_rsp_valid) begin
            wb_data_d = ld_data;
            wb_rd_d   = rd_q;
            state_d   = RESP;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         hit_q      <= 1'b0;
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
         rd_q       <= 5'd0;
         be_q       <= 4'b0000;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
`ifdef LSU_OUTPORT_EN
         outport_q  <= 32'd0;
`endif
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         hit_q      <= hit_d;
         we_q       <= we_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         rd_q       <= rd_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
`ifdef LSU_OUTPORT_EN
         outport_q  <= outport_d;
`endif
      end
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the RV32I core, directly downstream of decode/execute.
- Takes LOAD/STORE requests: funct3 width code, effective address from the ALU, and store data from rs2.
- Drives a word-wide ready/valid data-memory port with byte enables.
- Returns sign- or zero-extended load data to the regfile writeback mux (FROM_MEM path) and flags misaligned or illegal accesses.

Parameters:
- ADDR_W, 32, width of effective address and memory address.
- OUTPORT_ADDR, 32'h0000_FFFC, word address of the memory-mapped output port (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute presents a load/store
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = STORE opcode, 0 = LOAD opcode
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  effective address
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits = 0
- mem_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- fault  out  1  one-cycle pulse, misaligned or illegal access

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE
  - mem_req_valid = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0
  - wb_valid = 0, wb_rd = 0, wb_data = 0
  - fault = 0
  - req_ready = 1 from the first cycle after reset
- req_ready = (state == IDLE), decoded combinationally from state. A request is accepted on req_valid & req_ready, and all req_* fields are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE, on accept:
  - illegal funct3 (011, 110, 111; or store with funct3[2] = 1) -> ERR.
  - H with addr[0] = 1, or W with addr[1:0] != 0 -> ERR.
  - otherwise -> ISSUE.
- ERR: fault = 1 for exactly one cycle; no memory request; no wb_valid; -> IDLE.
- ISSUE:
  - mem_req_valid = 1; mem_addr, mem_we, mem_be, mem_wdata are held stable until mem_req_ready.
  - On handshake: store -> IDLE; load -> WAIT.
  - If mem_req_ready is already high in the first ISSUE cycle, the handshake completes that cycle.
- Store encoding:
  - B: be = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}
  - H: be = 4'b0011 << addr[1:0], wdata = {2{wdata[15:0]}}
  - W: be = 4'b1111
- WAIT: on mem_rsp_valid, select lane by addr[1:0] (half uses addr[1]), extend per funct3, register into wb_data, -> RESP.
  - B/H sign-extend; BU/HU zero-extend.
  - A mem_rsp_valid seen in any state other than WAIT is ignored.
- RESP: wb_valid = 1 with wb_rd and wb_data for one cycle; -> IDLE. wb_data holds its value until the next load.
- Minimum latency:
  - Accept at T, mem_req_valid at T+1.
  - With ready at T+1 and rsp at T+2, wb_valid is at T+3; next accept at T+4.
  - A store with immediate ready is back in IDLE at T+2.
- Reset mid-operation abandons the transaction. mem_req_valid drops the following cycle; no wb_valid or fault is emitted for the abandoned request.

Optional Feature:
- Macro: LSU_OUTPORT_EN.
- Defined:
  - Adds port `outport out 32`, reset 0.
  - A SW whose req_addr == OUTPORT_ADDR writes req_wdata into outport in the ISSUE cycle, with no memory request, then -> IDLE.
  - SB/SH and loads to that address go to memory normally.
- Undefined: no outport port; all stores go to memory.

Test Plan:
- LB addr 0x103, mem_rdata 0x80_12_34_56 -> mem_addr 0x100, mem_we 0, wb_data 0xFFFF_FF80, wb_valid one cycle at T+3 with zero-wait memory.
- LHU addr 0x202, mem_rdata 0xBEEF_1234 -> wb_data 0x0000_BEEF; LH same stimulus -> 0xFFFF_BEEF.
- SB addr 0x11, wdata 0xAABB_CCDD -> mem_be 4'b0010, mem_wdata 0xDDDD_DDDD, mem_we 1; mem_req_ready low 3 cycles -> request fields stable throughout; no wb_valid.
- LW addr 0x6 -> fault pulse one cycle, no mem_req_valid, no wb_valid. Store with funct3 100 -> fault.
- Reset asserted in WAIT, then mem_rsp_valid arrives -> no wb_valid, req_ready = 1 the cycle after reset deasserts.
- LSU_OUTPORT_EN defined: SW 0xFFFC, wdata 0x0000_0042 -> outport = 0x42, mem_req_valid never asserted. Undefined: same SW -> memory write with be 4'b1111.
